// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_N_DEFAULT = 8;

    // Step counter must hold the value N itself, hence N+1 codes.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/div_fa.sv
// One-bit full-adder cell used to build ripple arithmetic.
module div_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/div_sub_step.sv
// W-bit trial subtraction rem - B as rem + ~B + 1 over a ripple of full adders.
module div_sub_step #(
    parameter int W = 9
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] B,
    output logic [W-1:0] diff,
    output logic         neg
);

    logic [W:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < W; i++) begin : g_bit
        div_fa u_fa (
            .a  (rem[i]),
            .b  (~B[i]),
            .ci (c[i]),
            .s  (diff[i]),
            .co (c[i+1])
        );
    end

    // No carry out of the top bit means the subtraction borrowed.
    assign neg = ~c[W];

endmodule

// File: rtl/div_restoring_seq.sv
// Sequential N-cycle restoring divider for unsigned operands.
// Optional build macro DIV_ZERO_CHECK_EN short-cuts B=0 straight to DONE with div_zero set.
module div_restoring_seq
    import div_pkg::*;
#(
    parameter int N = DIV_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         div_zero
);

    localparam int CW = cnt_w(N);

    div_state_t    state, state_nxt;
    logic [N:0]    rem;
    logic [N-1:0]  dq;
    logic [N-1:0]  b_r;
    logic [CW-1:0] cnt;
    logic [N-1:0]  q_r;
    logic [N-1:0]  r_r;

    logic          accept;
    logic          last_step;
    logic [2*N:0]  pair_sh;
    logic [N:0]    shifted;
    logic [N:0]    diff;
    logic          neg;
    logic [N:0]    rem_nxt;
    logic [N-1:0]  dq_nxt;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last_step = (cnt == CW'(1));

    // Shift {rem, dividend} left; the freed quotient LSB is filled from the trial result.
    assign pair_sh = {rem, dq} << 1;
    assign shifted = pair_sh[2*N:N];
    assign dq_nxt  = pair_sh[N-1:0] | {{(N-1){1'b0}}, ~neg};
    assign rem_nxt = neg ? shifted : diff;

    div_sub_step #(.W(N + 1)) u_sub (
        .rem  (shifted),
        .B    ({1'b0, b_r}),
        .diff (diff),
        .neg  (neg)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
`ifdef DIV_ZERO_CHECK_EN
                    state_nxt = (B == '0) ? DONE : CALC;
`else
                    state_nxt = CALC;
`endif
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC:    if (last_step) state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem <= '0;
            dq  <= '0;
            b_r <= '0;
            cnt <= '0;
            q_r <= '0;
            r_r <= '0;
        end else if (accept) begin
            rem <= '0;
            dq  <= A;
            b_r <= B;
            cnt <= CW'(N);
`ifdef DIV_ZERO_CHECK_EN
            if (B == '0) begin
                q_r <= '1;
                r_r <= A;
            end
`endif
        end else if (state == CALC) begin
            rem <= rem_nxt;
            dq  <= dq_nxt;
            cnt <= cnt - CW'(1);
            if (last_step) begin
                q_r <= dq_nxt;
                r_r <= rem_nxt[N-1:0];
            end
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    logic dz_r;

    always_ff @(posedge clk) begin
        if (rst)         dz_r <= 1'b0;
        else if (accept) dz_r <= (B == '0);
    end

    assign div_zero = dz_r;
`else
    assign div_zero = 1'b0;
`endif

    assign Q = q_r;
    assign R = r_r;

endmodule

// File: tb/tb_div_restoring_seq.sv
// Directed and swept checks of div_restoring_seq (N=8) with immediate assertions.
module tb_div_restoring_seq;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] A = '0;
    logic [N-1:0] B = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         div_zero;

    int nvec = 0;
    int nmis = 0;

`ifdef DIV_ZERO_CHECK_EN
    localparam int ZLAT = 0;
    localparam int ZDZ  = 1;
`else
    localparam int ZLAT = N;
    localparam int ZDZ  = 0;
`endif

    always #5 clk = ~clk;

    div_restoring_seq #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .A        (A),
        .B        (B),
        .busy     (busy),
        .done     (done),
        .Q        (Q),
        .R        (R),
        .div_zero (div_zero)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [N-1:0] a, input logic [N-1:0] b);
        start = 1'b1;
        A     = a;
        B     = b;
        step(1);
        start = 1'b0;
    endtask

    // lat counts edges from the accepting edge until done is seen.
    task automatic wait_done(output int lat, output int bcnt);
        int both;
        lat  = 0;
        bcnt = 0;
        both = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (busy && done) both = 1;
            step(1);
            lat++;
        end
        if (busy && done) both = 1;
        chk("done_seen", {31'd0, done}, 32'd1);
        chk("busy_done_excl", both, 32'd0);
    endtask

    initial begin
        int lat, bc, dcnt;
        logic [N-1:0] a, b;
        int eq, er, ez;

        // Reset with start held high: reset must win.
        start = 1'b1; A = 8'd9; B = 8'd3;
        step(2);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", Q, 32'd0);
        chk("rst_r", R, 32'd0);
        chk("rst_dz", {31'd0, div_zero}, 32'd0);
        start = 1'b0; rst = 1'b0;
        step(2);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 100 / 7
        go(8'd100, 8'd7);
        wait_done(lat, bc);
        chk("t1_lat", lat, N);
        chk("t1_busycnt", bc, N);
        chk("t1_q", Q, 32'd14);
        chk("t1_r", R, 32'd2);
        chk("t1_dz", {31'd0, div_zero}, 32'd0);
        step(1);
        chk("t1_done_pulse", {31'd0, done}, 32'd0);
        step(2);
        chk("t1_hold_q", Q, 32'd14);
        chk("t1_hold_r", R, 32'd2);

        // 255 / 1 then back-to-back 5 / 9
        go(8'd255, 8'd1);
        wait_done(lat, bc);
        chk("t2a_q", Q, 32'd255);
        chk("t2a_r", R, 32'd0);
        go(8'd5, 8'd9);
        chk("t2_b2b_busy", {31'd0, busy}, 32'd1);
        wait_done(lat, bc);
        chk("t2b_lat", lat, N);
        chk("t2b_q", Q, 32'd0);
        chk("t2b_r", R, 32'd5);

        // Divide by zero
        go(8'hA5, 8'h00);
        wait_done(lat, bc);
        chk("t3_lat", lat, ZLAT);
        chk("t3_q", Q, 32'hFF);
        chk("t3_r", R, 32'hA5);
        chk("t3_dz", {31'd0, div_zero}, ZDZ);
        step(1);

        // start during CALC must be ignored
        go(8'd50, 8'd6);
        step(2);
        start = 1'b1; A = 8'd9; B = 8'd2;
        step(1);
        start = 1'b0;
        wait_done(lat, bc);
        chk("t4_lat", lat, N - 3);
        chk("t4_q", Q, 32'd8);
        chk("t4_r", R, 32'd2);
        step(1);

        // Reset mid-CALC aborts without done
        go(8'd77, 8'd4);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_q", Q, 32'd0);
        chk("t5_r", R, 32'd0);
        chk("t5_dz", {31'd0, div_zero}, 32'd0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dcnt++;
            step(1);
        end
        chk("t5_no_done", dcnt, 32'd0);
        go(8'd200, 8'd13);
        wait_done(lat, bc);
        chk("t5_q2", Q, 32'd15);
        chk("t5_r2", R, 32'd5);

        // Edge vectors followed by a randomized sweep
        for (int i = 0; i < 28; i++) begin
            case (i)
                0:       begin a = 8'd7;   b = 8'd200; end
                1:       begin a = 8'd255; b = 8'd255; end
                2:       begin a = 8'd128; b = 8'd2;   end
                3:       begin a = 8'd0;   b = 8'd5;   end
                4:       begin a = 8'd254; b = 8'd255; end
                default: begin
                    a = 8'($urandom_range(0, 255));
                    b = (i % 9 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
                end
            endcase
            if (b == 0) begin
                eq = 255; er = int'(a); ez = ZDZ;
            end else begin
                eq = int'(a) / int'(b); er = int'(a) % int'(b); ez = 0;
            end
            go(a, b);
            wait_done(lat, bc);
            chk($sformatf("sw%0d_q_%0d_%0d", i, a, b), Q, eq);
            chk($sformatf("sw%0d_r_%0d_%0d", i, a, b), R, er);
            chk($sformatf("sw%0d_dz", i), {31'd0, div_zero}, ez);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/div_restoring_seq.md
DIV_RESTORING_SEQ -- requirements
Module: div_restoring_seq

Interface
REQ-001 SHALL have parameter: N, default 8, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port: start  input  1  request to begin a division.
REQ-005 SHALL have port: A  input  N  unsigned dividend, sampled when start is accepted.
REQ-006 SHALL have port: B  input  N  unsigned divisor, sampled when start is accepted.
REQ-007 SHALL have port: busy  output  1  high while a division is in progress.
REQ-008 SHALL have port: done  output  1  one-cycle pulse when Q/R become valid.
REQ-009 SHALL have port: Q  output  N  quotient.
REQ-010 SHALL have port: R  output  N  remainder.
REQ-011 SHALL have port: div_zero  output  1  divisor-was-zero flag, valid with done.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE; reset state IDLE.
REQ-013 SHALL accept start only in IDLE or DONE; start in CALC SHALL be ignored, with no effect on state, operands or outputs.
REQ-014 SHALL on accept latch A and B, clear the partial remainder (N+1 bits), load the step counter with N, and enter CALC.
REQ-015 SHALL per CALC cycle: shift {rem, dividend} left by one; form diff = rem - {1'b0,B} in N+1 bits; if diff MSB = 0, set rem = diff and the quotient LSB to 1, else keep rem and set the quotient LSB to 0.
REQ-016 SHALL leave CALC for DONE after exactly N CALC cycles; done SHALL be high only during the single DONE cycle, i.e. N+1 cycles after the accepting edge.
REQ-017 SHALL hold Q, R and div_zero stable from done until the next accepted start, including while in IDLE.
REQ-018 SHALL assert busy in CALC only; busy and done SHALL never both be high.
REQ-019 SHALL move DONE->IDLE the next cycle, or DONE->CALC when start is high in DONE (back-to-back, no idle gap).
REQ-020 SHALL give Q = all ones and R = A for B = 0 (natural restoring result).
REQ-021 SHALL produce Q = floor(A/B) and R = A mod B for every B != 0, with R < B.

Reset
REQ-022 SHALL on rst=1 at a clock edge force IDLE and busy=0, done=0, Q=0, R=0, div_zero=0, regardless of state, including mid-CALC.
REQ-023 SHALL give rst priority over start in the same cycle; the aborted operation SHALL produce no done.

Configuration
REQ-024 SHALL use macro DIV_ZERO_CHECK_EN.
REQ-025 SHALL with DIV_ZERO_CHECK_EN defined: on accept with B=0, skip CALC, go directly to DONE (done one cycle after accept), with Q=all ones, R=A, div_zero=1.
REQ-026 SHALL with DIV_ZERO_CHECK_EN undefined: run B=0 through the full N-cycle CALC per REQ-020, with div_zero tied to 0.

Structure
REQ-027 SHALL place in shared package div_pkg: the state enum type (IDLE/CALC/DONE), default width constant DIV_N_DEFAULT = 8, and the counter width function/constant.
REQ-028 SHALL isolate the N+1-bit trial subtraction in sub-module div_sub_step, with inputs rem and B and outputs diff and a borrow/negative flag, built as a ripple chain of the team's full-adder cell with inverted B and carry-in 1.
REQ-029 SHALL keep all sequencing (FSM, counter, shift registers) in div_restoring_seq.

Verification
REQ-030 SHALL cover: A=100, B=7, start pulse -> done 9 cycles later, Q=14, R=2, div_zero=0, busy high for 8 cycles.
REQ-031 SHALL cover: A=255, B=1 then back-to-back start in DONE with A=5, B=9 -> Q=255, R=0; then Q=0, R=5, with no IDLE cycle between.
REQ-032 SHALL cover: A=0xA5, B=0 -> with DIV_ZERO_CHECK_EN: done 1 cycle after accept, Q=0xFF, R=0xA5, div_zero=1; without it: done after 9 cycles, Q=0xFF, R=0xA5, div_zero=0.
REQ-033 SHALL cover: start re-asserted with new A/B at CALC cycle 3 -> ignored; result matches the first operands.
REQ-034 SHALL cover: rst asserted at CALC cycle 4 -> next cycle IDLE, all outputs 0, no done pulse; a subsequent A=200, B=13 -> Q=15, R=5.
REQ-035 SHALL cover: randomized A,B sweep (N=8) checked against A/B and A%B reference model.
